// File: rtl/muldiv_pkg.sv
// Shared types and opcode decode helpers for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_rs1(input muldiv_op_e op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic is_signed_rs2(input muldiv_op_e op);
    return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step on the {hi, lo} accumulator: shift-add for multiply, restoring
// subtract-shift for divide. Purely combinational.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_opnd,
  input  logic [2*XLEN-1:0] i_acc,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_part;
  logic [XLEN-1:0] w_sub;
  logic            w_ge;

  always_comb begin
    // Multiply: the carry out of the add becomes the new top bit after the right shift.
    w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
    w_part = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
    w_ge   = (w_part >= {1'b0, i_opnd});
    w_sub  = w_part[XLEN-1:0] - i_opnd;
    if (i_is_div) begin
      o_acc = {(w_ge ? w_sub : w_part[XLEN-1:0]), i_acc[XLEN-2:0], w_ge};
    end else begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: XLEN/BPC CALC cycles then DONE (fast paths go straight to DONE).
// Accepts only in IDLE; the result is held in DONE until popped; flush returns to IDLE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_in_1,
  input  logic [XLEN-1:0] i_in_2,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [XLEN-1:0] o_out,
  output logic            o_zero,
  output logic            o_sign
);

  localparam int K  = XLEN / BPC;
  localparam int CW = $clog2(K + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  if (!(XLEN == 16 || XLEN == 32 || XLEN == 64) || BPC < 1 || (XLEN % BPC) != 0) begin : g_bad_cfg
    $fatal(1, "muldiv_unit: XLEN must be 16/32/64 and BPC must divide XLEN");
  end

  state_e          r_state;
  state_e          w_state_nxt;
  muldiv_op_e      r_op;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic [XLEN-1:0] r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_out;
  logic            r_zero;
  logic            r_sign;

  muldiv_op_e      w_op;
  logic            w_accept;
  logic            w_neg1;
  logic            w_neg2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic            w_div0;
  logic            w_ovf;
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;
  logic            w_last;
  logic            w_load_out;
  logic            w_is_div;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quot;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_calc_res;
  logic [XLEN-1:0] w_res_nxt;
  logic [2*XLEN-1:0] w_chain [BPC+1];

  assign w_op     = muldiv_op_e'(i_op);
  assign w_accept = i_in_valid & o_in_ready;
  assign w_neg1   = is_signed_rs1(w_op) & i_in_1[XLEN-1];
  assign w_neg2   = is_signed_rs2(w_op) & i_in_2[XLEN-1];
  assign w_mag1   = w_neg1 ? -i_in_1 : i_in_1;
  assign w_mag2   = w_neg2 ? -i_in_2 : i_in_2;
  assign w_div0   = is_div(w_op) & (i_in_2 == '0);
  assign w_ovf    = ((w_op == DIV) || (w_op == REM)) & (i_in_1 == MIN) & (i_in_2 == {XLEN{1'b1}});
  assign w_fast   = w_div0 | w_ovf;
  assign w_last   = (r_cnt == CW'(K - 1));
  assign w_is_div = is_div(r_op);

  always_comb begin
    w_fast_res = '0;
    if (w_div0) begin
      w_fast_res = is_rem(w_op) ? i_in_1 : {XLEN{1'b1}};
    end else if (!is_rem(w_op)) begin
      w_fast_res = MIN;
    end
  end

  assign w_chain[0] = r_acc;
  for (genvar g = 0; g < BPC; g++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .i_is_div (w_is_div),
      .i_opnd   (r_opnd),
      .i_acc    (w_chain[g]),
      .o_acc    (w_chain[g+1])
    );
  end
  assign w_acc_nxt = w_chain[BPC];

  // Sign fixup on the final accumulator; remainder follows the dividend's sign.
  assign w_prod = r_neg_res ? -w_acc_nxt : w_acc_nxt;
  assign w_quot = r_neg_res ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
  assign w_rem  = r_neg_rem ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    w_calc_res = w_rem;
    case (r_op)
      MUL:                 w_calc_res = w_prod[XLEN-1:0];
      MULH, MULHSU, MULHU: w_calc_res = w_prod[2*XLEN-1:XLEN];
      DIV, DIVU:           w_calc_res = w_quot;
      default:             w_calc_res = w_rem;
    endcase
  end

  assign w_load_out = (w_accept & w_fast) | ((r_state == CALC) & w_last & !i_flush);
  assign w_res_nxt  = w_accept ? w_fast_res : w_calc_res;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = (r_state == IDLE) & !i_flush & !i_rst;
    o_out_valid = (r_state == DONE);
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_fast ? DONE : CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    if (i_out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (i_flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op      <= MUL;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_out     <= '0;
      r_zero    <= 1'b1;
      r_sign    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= w_op;
        r_neg_res <= w_neg1 ^ w_neg2;
        r_neg_rem <= w_neg1;
        r_cnt     <= '0;
        // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
        if (is_div(w_op)) begin
          r_opnd <= w_mag2;
          r_acc  <= {{XLEN{1'b0}}, w_mag1};
        end else begin
          r_opnd <= w_mag1;
          r_acc  <= {{XLEN{1'b0}}, w_mag2};
        end
      end else if (r_state == CALC) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_load_out) begin
        r_out  <= w_res_nxt;
        r_zero <= (w_res_nxt == '0);
        r_sign <= w_res_nxt[XLEN-1];
      end
    end
  end

  assign o_out  = r_out;
  assign o_zero = r_zero;
  assign o_sign = r_sign;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases on a 32/1 instance, randomized ops on 32/1 and 16/4
// instances against an arithmetic reference model, plus hold, flush and reset scenarios.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_zero, a_sign;
  logic [2:0]  a_op;
  logic [31:0] a_in_1, a_in_2, a_out;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zero, b_sign;
  logic [2:0]  b_op;
  logic [15:0] b_in_1, b_in_2, b_out;

  muldiv_unit #(.XLEN(32), .BPC(1)) u_dut32 (
    .i_clk(clk), .i_rst(rst), .i_flush(a_flush), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
    .i_op(a_op), .i_in_1(a_in_1), .i_in_2(a_in_2), .o_out_valid(a_out_valid),
    .i_out_ready(a_out_ready), .o_out(a_out), .o_zero(a_zero), .o_sign(a_sign)
  );

  muldiv_unit #(.XLEN(16), .BPC(4)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_flush(b_flush), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
    .i_op(b_op), .i_in_1(b_in_1), .i_in_2(b_in_2), .o_out_valid(b_out_valid),
    .i_out_ready(b_out_ready), .o_out(b_out), .o_zero(b_zero), .o_sign(b_sign)
  );

  localparam logic [2:0]  T_OP [13] = '{MUL, MULH, MULHSU, MULHU, DIV, REM, DIVU, REMU, REM,
                                        DIVU, REM, DIV, REM};
  localparam logic [31:0] T_A  [13] = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                        32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7,
                                        32'd5, 32'd5, 32'h80000000, 32'h80000000};
  localparam logic [31:0] T_B  [13] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                        32'd2, 32'd2, 32'd7, 32'd7, 32'd7,
                                        32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam logic [31:0] T_E  [13] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
                                        32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'd0,
                                        32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
  localparam int          T_L  [13] = '{33, 33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};

  // RISC-V M-extension result from plain integer arithmetic.
  function automatic logic [63:0] ref_res(input int xlen, input logic [2:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    longint unsigned ua, ub, mn, r;
    longint sa, sb, q;
    mask = (64'd1 << xlen) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    mn = 64'd1 << (xlen - 1);
    sa = ua[xlen-1] ? longint'(ua | ~mask) : longint'(ua);
    sb = ub[xlen-1] ? longint'(ub | ~mask) : longint'(ub);
    r = 0;
    case (op)
      3'd0: begin q = sa * sb; r = q; end
      3'd1: begin q = (sa * sb) >>> xlen; r = q; end
      3'd2: begin q = (sa * longint'(ub)) >>> xlen; r = q; end
      3'd3: r = (ua * ub) >> xlen;
      3'd4: if (ub == 0) r = mask; else if (ua == mn && ub == mask) r = mn;
            else begin q = sa / sb; r = q; end
      3'd5: if (ub == 0) r = mask; else r = ua / ub;
      3'd6: if (ub == 0) r = ua; else if (ua == mn && ub == mask) r = 0;
            else begin q = sa % sb; r = q; end
      default: if (ub == 0) r = ua; else r = ua % ub;
    endcase
    return r & mask;
  endfunction

  function automatic logic is_fast(input int xlen, input logic [2:0] op,
                                   input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    mask = (64'd1 << xlen) - 64'd1;
    if (op >= 3'd4 && (b & mask) == 0) return 1'b1;
    if ((op == 3'd4 || op == 3'd6) && (a & mask) == (64'd1 << (xlen - 1)) && (b & mask) == mask)
      return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] rand_opnd(input int xlen);
    logic [63:0] m;
    m = (64'd1 << xlen) - 64'd1;
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return m;
      2: return 64'd1 << (xlen - 1);
      3: return 64'd1;
      4: return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after popping the result.
  task automatic do_op32(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input int dly, output logic [31:0] res, output logic z,
                         output logic s, output int lat);
    int n;
    n = 0;
    while (!a_in_ready && n < 100) begin @(posedge clk); #1; n++; end
    a_op = op; a_in_1 = x; a_in_2 = y; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!a_out_valid && lat < 200) begin @(negedge clk); lat++; end
    repeat (dly) @(negedge clk);
    res = a_out; z = a_zero; s = a_sign;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic do_op16(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                         input int dly, output logic [15:0] res, output logic z,
                         output logic s, output int lat);
    int n;
    n = 0;
    while (!b_in_ready && n < 100) begin @(posedge clk); #1; n++; end
    b_op = op; b_in_1 = x; b_in_2 = y; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!b_out_valid && lat < 200) begin @(negedge clk); lat++; end
    repeat (dly) @(negedge clk);
    res = b_out; z = b_zero; s = b_sign;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out !== 32'h0) begin errors++; $display("FAIL reset out: got %h expected 0", a_out); end
    checks++; if (a_zero !== 1'b1) begin errors++; $display("FAIL reset zero: got %b expected 1", a_zero); end
    checks++; if (a_sign !== 1'b0) begin errors++; $display("FAIL reset sign: got %b expected 0", a_sign); end
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset16 in_ready: got %b expected 1", b_in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] r;
    logic z, s;
    int lat;
    for (int i = 0; i < 13; i++) begin
      do_op32(T_OP[i], T_A[i], T_B[i], 0, r, z, s, lat);
      checks++; if (r !== T_E[i]) begin errors++; $display("FAIL dir[%0d] out: got %h expected %h", i, r, T_E[i]); end
      checks++; if (z !== (T_E[i] == 32'h0)) begin errors++; $display("FAIL dir[%0d] zero: got %b expected %b", i, z, T_E[i] == 32'h0); end
      checks++; if (s !== T_E[i][31]) begin errors++; $display("FAIL dir[%0d] sign: got %b expected %b", i, s, T_E[i][31]); end
      checks++; if (lat !== T_L[i]) begin errors++; $display("FAIL dir[%0d] latency: got %0d expected %0d", i, lat, T_L[i]); end
    end
  endtask

  task automatic test_hold();
    logic [63:0] e;
    int n;
    e = ref_res(32, MULHU, 64'hFFFFFFFF, 64'hFFFFFFFF);
    a_op = MULHU; a_in_1 = 32'hFFFFFFFF; a_in_2 = 32'hFFFFFFFF; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!a_out_valid && n < 200) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (a_out !== e[31:0]) begin errors++; $display("FAIL hold[%0d] out: got %h expected %h", i, a_out, e[31:0]); end
      checks++; if (a_zero !== 1'b0 || a_sign !== 1'b1) begin errors++; $display("FAIL hold[%0d] flags: got z%b s%b expected z0 s1", i, a_zero, a_sign); end
      checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin errors++; $display("FAIL hold[%0d] handshake: got rdy%b vld%b expected rdy0 vld1", i, a_in_ready, a_out_valid); end
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL pop: got vld%b rdy%b expected vld0 rdy1", a_out_valid, a_in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_calc();
    int seen;
    a_op = DIVU; a_in_1 = $urandom; a_in_2 = $urandom | 32'h1; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    a_flush = 1'b1;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_calc busy: got in_ready %b expected 0", a_in_ready); end
    @(posedge clk); #1;
    a_flush = 1'b0;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_calc idle: got rdy%b vld%b expected rdy1 vld0", a_in_ready, a_out_valid); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (a_out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_calc result: got %0d valid cycles expected 0", seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_idle();
    int seen;
    logic [31:0] r;
    logic z, s;
    int lat;
    a_op = DIVU; a_in_1 = 32'd100; a_in_2 = 32'd7; a_in_valid = 1'b1; a_flush = 1'b1;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_idle ready: got %b expected 0", a_in_ready); end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_flush = 1'b0;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle accepted: got in_ready %b expected 1", a_in_ready); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (a_out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_idle result: got %0d valid cycles expected 0", seen); end
    @(posedge clk); #1;
    do_op32(REMU, 32'd100, 32'd7, 0, r, z, s, lat);
    checks++; if (r !== 32'd2) begin errors++; $display("FAIL after_flush out: got %h expected 2", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic z, s;
    int lat, seen;
    do_op32(MUL, 32'h7, 32'hFFFFFFFD, 0, r, z, s, lat);
    a_op = DIV; a_in_1 = $urandom; a_in_2 = $urandom | 32'h1; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_out !== 32'h0) begin errors++; $display("FAIL rst_mid async: got vld%b out %h expected vld0 out 0", a_out_valid, a_out); end
    checks++; if (a_zero !== 1'b1 || a_sign !== 1'b0) begin errors++; $display("FAIL rst_mid flags: got z%b s%b expected z1 s0", a_zero, a_sign); end
    #2 rst = 1'b0;
    @(negedge clk);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid ready: got %b expected 1", a_in_ready); end
    seen = 0;
    repeat (50) begin @(negedge clk); if (a_out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid result: got %0d valid cycles expected 0", seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_random32();
    logic [63:0] x, y, e;
    logic [2:0] op;
    logic [31:0] r;
    logic z, s;
    int lat, el;
    for (int i = 0; i < 100; i++) begin
      op = 3'($urandom_range(0, 7));
      x = rand_opnd(32);
      y = rand_opnd(32);
      e = ref_res(32, op, x, y);
      el = is_fast(32, op, x, y) ? 1 : 33;
      do_op32(op, x[31:0], y[31:0], $urandom_range(0, 2), r, z, s, lat);
      checks++; if (r !== e[31:0] || z !== (e[31:0] == 32'h0) || s !== e[31])
        begin errors++; $display("FAIL rand32 op%0d %h,%h: got %h z%b s%b expected %h", op, x[31:0], y[31:0], r, z, s, e[31:0]); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rand32 latency op%0d: got %0d expected %0d", op, lat, el); end
    end
  endtask

  task automatic test_back_to_back16();
    logic [63:0] x, y, e;
    logic [2:0] op;
    logic [15:0] r;
    logic z, s;
    int lat, el;
    for (int i = 0; i < 2000; i++) begin
      op = 3'($urandom_range(0, 7));
      x = rand_opnd(16);
      y = rand_opnd(16);
      e = ref_res(16, op, x, y);
      el = is_fast(16, op, x, y) ? 1 : 5;
      do_op16(op, x[15:0], y[15:0], $urandom_range(0, 2), r, z, s, lat);
      checks++; if (r !== e[15:0] || z !== (e[15:0] == 16'h0) || s !== e[15])
        begin errors++; $display("FAIL rand16 op%0d %h,%h: got %h z%b s%b expected %h", op, x[15:0], y[15:0], r, z, s, e[15:0]); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rand16 latency op%0d: got %0d expected %0d", op, lat, el); end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_op = 3'd0; a_in_1 = '0; a_in_2 = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_op = 3'd0; b_in_1 = '0; b_in_2 = '0;
    test_reset();
    test_directed();
    test_hold();
    test_flush_calc();
    test_flush_idle();
    test_reset_mid();
    test_random32();
    test_back_to_back16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
